// File: rtl/code_checker.sv
// Entry-verification stage: checks a keyed-in code digit by digit,
// reports pass/fail to the status display, and locks out after repeated failures.
module code_checker #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int MAX_TRIES = 3,
  localparam int CW = $clog2(DIGITS+1),
  localparam int TW = $clog2(MAX_TRIES+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               enter,
  input  logic               clear,
  output logic               done,
  output logic               incorrect,
  output logic               locked,
  output logic [CW-1:0]      digit_count,
  output logic [TW-1:0]      tries_left
);

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    RESULT = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, n_state;

  logic          enter_q, clear_q;
  logic          enter_rise, clear_rise;
  logic          mismatch, n_mismatch, mm_next;
  logic          n_done, n_incorrect, n_locked;
  logic [CW-1:0] n_count;
  logic [TW-1:0] n_tries;
  logic [DIGIT_W-1:0] exp_digit;

  assign enter_rise = enter & ~enter_q;
  assign clear_rise = clear & ~clear_q;

  // Expected digit for the current position; index 0 is the MS digit.
  always_comb begin
    exp_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_count == CW'(i))
        exp_digit = CODE[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  assign mm_next = mismatch | (digit_in != exp_digit);

  always_comb begin
    n_state     = state;
    n_done      = done;
    n_incorrect = incorrect;
    n_locked    = locked;
    n_count     = digit_count;
    n_tries     = tries_left;
    n_mismatch  = mismatch;
    unique case (state)
      ENTRY: begin
        if (clear_rise) begin
          n_count    = '0;
          n_mismatch = 1'b0;
        end else if (enter_rise) begin
          if (digit_count != CW'(DIGITS-1)) begin
            n_count    = digit_count + CW'(1);
            n_mismatch = mm_next;
          end else begin
            n_count     = CW'(DIGITS);
            n_mismatch  = mm_next;
            n_done      = 1'b1;
            n_incorrect = mm_next;
            if (!mm_next) begin
              n_tries = TW'(MAX_TRIES);
              n_state = RESULT;
            end else if (tries_left > TW'(1)) begin
              n_tries = tries_left - TW'(1);
              n_state = RESULT;
            end else begin
              n_tries  = '0;
              n_locked = 1'b1;
              n_state  = LOCKED;
            end
          end
        end
      end
      RESULT: begin
        if (clear_rise) begin
          n_done      = 1'b0;
          n_incorrect = 1'b0;
          n_count     = '0;
          n_mismatch  = 1'b0;
          n_state     = ENTRY;
        end
      end
      LOCKED: begin
      end
      default: n_state = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      done        <= 1'b0;
      incorrect   <= 1'b0;
      locked      <= 1'b0;
      digit_count <= '0;
      tries_left  <= TW'(MAX_TRIES);
      mismatch    <= 1'b0;
      // Held high so a button pressed through reset is not a press.
      enter_q     <= 1'b1;
      clear_q     <= 1'b1;
    end else begin
      state       <= n_state;
      done        <= n_done;
      incorrect   <= n_incorrect;
      locked      <= n_locked;
      digit_count <= n_count;
      tries_left  <= n_tries;
      mismatch    <= n_mismatch;
      enter_q     <= enter;
      clear_q     <= clear;
    end
  end

endmodule

// File: tb/tb_code_checker.sv
// Directed self-checking bench for code_checker.
// Status vector = {done, incorrect, locked, digit_count[2:0], tries_left[1:0]}.
module tb_code_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       done, incorrect, locked;
  logic [2:0] digit_count;
  logic [1:0] tries_left;
  logic [7:0] st, ex;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  code_checker dut (
    .clk(clk), .rst(rst), .digit_in(digit_in),
    .enter(enter), .clear(clear),
    .done(done), .incorrect(incorrect), .locked(locked),
    .digit_count(digit_count), .tries_left(tries_left)
  );

  assign st = {done, incorrect, locked, digit_count, tries_left};

  function automatic logic [7:0] s(input logic d, input logic i,
      input logic l, input int c, input int t);
    return {d, i, l, 3'(c), 2'(t)};
  endfunction

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    enter = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    digit_in = 4'hf;
    @(negedge clk);
  endtask

  task automatic clr();
    @(negedge clk);
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL reset got=%b exp=%b", st, ex);
    end
  endtask

  task automatic test_pass();
    press(4'd1);
    ex = s(0, 0, 0, 1, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL pass_d1 got=%b exp=%b", st, ex);
    end
    press(4'd2);
    ex = s(0, 0, 0, 2, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL pass_d2 got=%b exp=%b", st, ex);
    end
    press(4'd3);
    ex = s(0, 0, 0, 3, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL pass_d3 got=%b exp=%b", st, ex);
    end
    @(negedge clk);
    digit_in = 4'd4;
    enter = 1'b1;
    @(posedge clk);
    #1;
    ex = s(1, 0, 0, 4, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL pass_latency got=%b exp=%b", st, ex);
    end
    repeat (3) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    clr();
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL pass_clear got=%b exp=%b", st, ex);
    end
  endtask

  task automatic test_fail();
    press(4'd1); press(4'd9); press(4'd3); press(4'd4);
    ex = s(1, 1, 0, 4, 2);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL fail_result got=%b exp=%b", st, ex);
    end
    press(4'd1);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL fail_enter_in_result got=%b exp=%b", st, ex);
    end
    clr();
    ex = s(0, 0, 0, 0, 2);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL fail_clear got=%b exp=%b", st, ex);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    ex = s(1, 0, 0, 4, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL fail_then_pass got=%b exp=%b", st, ex);
    end
    clr();
  endtask

  task automatic test_lockout();
    press(4'd5); press(4'd5); press(4'd5); press(4'd5);
    ex = s(1, 1, 0, 4, 2);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL lock_try1 got=%b exp=%b", st, ex);
    end
    clr();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5);
    ex = s(1, 1, 0, 4, 1);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL lock_try2 got=%b exp=%b", st, ex);
    end
    clr();
    press(4'd2); press(4'd2); press(4'd3); press(4'd4);
    ex = s(1, 1, 1, 4, 0);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL lock_try3 got=%b exp=%b", st, ex);
    end
    press(4'd1);
    clr();
    press(4'd1);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL lock_hold got=%b exp=%b", st, ex);
    end
    do_reset();
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL lock_reset got=%b exp=%b", st, ex);
    end
  endtask

  task automatic test_clear_mid();
    press(4'd1); press(4'd2);
    clr();
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL clrmid_count got=%b exp=%b", st, ex);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    ex = s(1, 0, 0, 4, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL clrmid_pass got=%b exp=%b", st, ex);
    end
    clr();
    press(4'd1); press(4'd2);
    @(negedge clk);
    digit_in = 4'd3;
    enter = 1'b1;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    enter = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL clr_wins got=%b exp=%b", st, ex);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    digit_in = 4'd1;
    enter = 1'b1;
    repeat (50) @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    ex = s(0, 0, 0, 1, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL hold_once got=%b exp=%b", st, ex);
    end
    clr();
    @(negedge clk);
    enter = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL hold_rst got=%b exp=%b", st, ex);
    end
    enter = 1'b0;
    @(negedge clk);
    press(4'd1);
    ex = s(0, 0, 0, 1, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL hold_repress got=%b exp=%b", st, ex);
    end
    clr();
  endtask

  task automatic test_reset_mid();
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    clr();
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    clr();
    ex = s(0, 0, 0, 0, 1);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL rmid_setup got=%b exp=%b", st, ex);
    end
    press(4'd7); press(4'd2); press(4'd3);
    ex = s(0, 0, 0, 3, 1);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL rmid_partial got=%b exp=%b", st, ex);
    end
    do_reset();
    ex = s(0, 0, 0, 0, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL rmid_reset got=%b exp=%b", st, ex);
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    ex = s(1, 0, 0, 4, 3);
    checks++;
    if (st !== ex) begin
      errors++;
      $display("FAIL rmid_pass got=%b exp=%b", st, ex);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_lockout();
    test_clear_mid();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
